wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the 16-bit pipeline; consumes the MEM/WB pipeline-register outputs (write enable, data-select, ALU result, memory data, destination register) and commits the selected value into an 8 × 16-bit register file. Provides two combinational read ports to decode with write-through bypass, so an instruction in decode sees a value being written back the same cycle. Also keeps a retired-write counter and last-write record for debug and verification.

## Interface
Parameters:
- NREGS, 8, number of architectural registers (index width 3)
- DWIDTH, 16, data width

Ports:
- CLK  input  1  clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset
- IRegWrite  input  1  MEM/WB write enable for this cycle
- IRegStore  input  1  data select: 1 = IStoreMem (load data), 0 = IALUResult
- IALUResult  input  16  ALU result from MEM/WB
- IStoreMem  input  16  memory read data from MEM/WB
- IRd  input  3  destination register index
- IRs1  input  3  decode read port 1 index
- IRs2  input  3  decode read port 2 index
- ORs1Data  output  16  read port 1 data (combinational, bypassed)
- ORs2Data  output  16  read port 2 data (combinational, bypassed)
- OWbData  output  16  selected write-back value this cycle (combinational)
- OWbValid  output  1  IRegWrite && IRd != 0 (combinational)
- ORetireCount  output  16  number of committed register writes
- OLastRd  output  3  index of most recently committed write
- OLastData  output  16  value of most recently committed write

## Operation
- OWbData = IRegStore ? IStoreMem : IALUResult.
- Register 0 hardwired to 0x0000: writes with IRd == 0 discarded; reads of index 0 return 0 regardless of bypass.
- Commit: on rising CLK with OWbValid = 1, reg[IRd] <= OWbData, ORetireCount <= ORetireCount + 1 (mod 2^16, wraps 0xFFFF → 0x0000), OLastRd <= IRd, OLastData <= OWbData.
- IRegWrite = 0 or IRd = 0: no register, counter, or last-write change.
- Read port n: if IRsn == 0 → 0; else if OWbValid && IRsn == IRd → OWbData (bypass); else reg[IRsn]. Both ports independent; both may bypass same cycle.
- IRegStore ignored when IRegWrite = 0.

## Timing
- Reset (Reset = 0, asynchronous assert, synchronous-to-CLK deassert expected): all registers 0x0000, ORetireCount 0, OLastRd 0, OLastData 0x0000. Combinational outputs follow inputs during reset; read ports return 0 (all registers cleared, bypass still active for nonzero IRd with OWbValid).
- Reset asserted mid-cycle: state cleared immediately; write pending that cycle is lost.
- Write latency: value visible on read ports same cycle via bypass, from register array from next cycle.
- No handshake, no stall: write-back never back-pressures; one commit per cycle max.

## Structure
- Shared package: DWIDTH, register-index width, REG_ZERO constant (3'd0), reset value constant.
- Natural sub-module: regfile_8x16 (array, single write port, two raw read ports, async active-low clear); wb_regfile adds select mux, zero-register rule, bypass, counter, last-write record.

## Test plan
- Reset: hold Reset = 0, drive IRs1 = 3, IRs2 = 7, IRegWrite = 0 → both reads 0x0000, ORetireCount 0, OLastRd 0.
- ALU write then read: IRegWrite = 1, IRegStore = 0, IALUResult = 0x1234, IRd = 3; next cycle IRegWrite = 0, IRs1 = 3 → ORs1Data 0x1234, ORetireCount 1, OLastRd 3, OLastData 0x1234.
- Load select + bypass: IRegWrite = 1, IRegStore = 1, IStoreMem = 0xBEEF, IALUResult = 0x0001, IRd = 5, IRs1 = IRs2 = 5 same cycle → OWbData, ORs1Data, ORs2Data all 0xBEEF before edge.
- Zero register: IRegWrite = 1, IRd = 0, IALUResult = 0xFFFF, IRs1 = 0 → ORs1Data 0, OWbValid 0, ORetireCount unchanged.
- Counter wrap: 65536 consecutive valid writes to r1 from reset → ORetireCount returns to 0x0000; r1 holds last value written.
- Mid-operation reset: r2 = 0xAAAA, assert Reset = 0 between edges with write to r2 = 0x5555 pending → r2 reads 0x0000 after release, ORetireCount 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back stage and register file.
package wb_regfile_pkg;

    localparam int WB_DWIDTH = 16;
    localparam int WB_NREGS  = 8;
    localparam int WB_IDXW   = 3;

    // Architectural register 0 is hardwired to zero.
    localparam logic [WB_IDXW-1:0]   REG_ZERO = 3'd0;
    // Value every piece of state takes on reset.
    localparam logic [WB_DWIDTH-1:0] RST_VAL  = 16'h0000;

    // Write-back data source select.
    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } wb_sel_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_rf.sv
// Register array: one synchronous write port, two raw asynchronous read
// ports, asynchronous active-low clear. No zero-register or bypass logic.
module regfile_8x16
    import wb_regfile_pkg::*;
#(
    parameter int NREGS  = WB_NREGS,
    parameter int DWIDTH = WB_DWIDTH,
    parameter int IW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [IW-1:0]     raddr1,
    input  logic [IW-1:0]     raddr2,
    output logic [DWIDTH-1:0] rdata1,
    output logic [DWIDTH-1:0] rdata2
);

    logic [DWIDTH-1:0] mem_r [NREGS];

    // Array update: clear everything on reset, else write one entry when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {DWIDTH{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata1 = mem_r[raddr1];
    assign rdata2 = mem_r[raddr2];

endmodule : regfile_8x16

// File: rtl/wb_regfile.sv
// Write-back stage: selects the commit value, applies the zero-register rule,
// bypasses the in-flight write to decode read ports, and keeps a retired-write
// counter plus a last-write record for debug.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NREGS  = WB_NREGS,
    parameter int DWIDTH = WB_DWIDTH,
    parameter int IW     = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IRegWrite,
    input  logic              IRegStore,
    input  logic [DWIDTH-1:0] IALUResult,
    input  logic [DWIDTH-1:0] IStoreMem,
    input  logic [IW-1:0]     IRd,
    input  logic [IW-1:0]     IRs1,
    input  logic [IW-1:0]     IRs2,
    output logic [DWIDTH-1:0] ORs1Data,
    output logic [DWIDTH-1:0] ORs2Data,
    output logic [DWIDTH-1:0] OWbData,
    output logic              OWbValid,
    output logic [DWIDTH-1:0] ORetireCount,
    output logic [IW-1:0]     OLastRd,
    output logic [DWIDTH-1:0] OLastData
);

    localparam logic [DWIDTH-1:0] ZERO_DATA = {DWIDTH{1'b0}};
    localparam logic [DWIDTH-1:0] ONE_DATA  = {{(DWIDTH-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]     ZERO_IDX  = {IW{1'b0}};

    logic [DWIDTH-1:0] wb_data_s;
    logic              wb_valid_s;
    logic [DWIDTH-1:0] rf_rs1_s;
    logic [DWIDTH-1:0] rf_rs2_s;
    logic [DWIDTH-1:0] rs1_data_s;
    logic [DWIDTH-1:0] rs2_data_s;
    logic [DWIDTH-1:0] retire_cnt_r;
    logic [IW-1:0]     last_rd_r;
    logic [DWIDTH-1:0] last_data_r;

    // Commit value select: load data or ALU result
    always_comb begin
        wb_data_s = IALUResult;
        case (wb_sel_e'(IRegStore))
            SEL_MEM: wb_data_s = IStoreMem;
            SEL_ALU: wb_data_s = IALUResult;
            default: wb_data_s = IALUResult;
        endcase
    end

    // A write only counts when it targets a real register
    always_comb begin
        wb_valid_s = 1'b0;
        if (IRegWrite && (IRd != REG_ZERO)) begin
            wb_valid_s = 1'b1;
        end else begin
            wb_valid_s = 1'b0;
        end
    end

    regfile_8x16 #(
        .NREGS  (NREGS),
        .DWIDTH (DWIDTH),
        .IW     (IW)
    ) u_rf (
        .clk    (CLK),
        .rst_n  (Reset),
        .we     (wb_valid_s),
        .waddr  (IRd),
        .wdata  (wb_data_s),
        .raddr1 (IRs1),
        .raddr2 (IRs2),
        .rdata1 (rf_rs1_s),
        .rdata2 (rf_rs2_s)
    );

    // Read port 1: zero register wins, then same-cycle bypass, then the array
    always_comb begin
        rs1_data_s = ZERO_DATA;
        if (IRs1 == REG_ZERO) begin
            rs1_data_s = ZERO_DATA;
        end else if (wb_valid_s && (IRs1 == IRd)) begin
            rs1_data_s = wb_data_s;
        end else begin
            rs1_data_s = rf_rs1_s;
        end
    end

    // Read port 2: same priority as port 1, fully independent
    always_comb begin
        rs2_data_s = ZERO_DATA;
        if (IRs2 == REG_ZERO) begin
            rs2_data_s = ZERO_DATA;
        end else if (wb_valid_s && (IRs2 == IRd)) begin
            rs2_data_s = wb_data_s;
        end else begin
            rs2_data_s = rf_rs2_s;
        end
    end

    // Debug record: count commits (wrapping) and remember the latest one
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            retire_cnt_r <= ZERO_DATA;
            last_rd_r    <= ZERO_IDX;
            last_data_r  <= ZERO_DATA;
        end else if (wb_valid_s) begin
            retire_cnt_r <= retire_cnt_r + ONE_DATA;
            last_rd_r    <= IRd;
            last_data_r  <= wb_data_s;
        end
    end

    assign OWbData      = wb_data_s;
    assign OWbValid     = wb_valid_s;
    assign ORs1Data     = rs1_data_s;
    assign ORs2Data     = rs2_data_s;
    assign ORetireCount = retire_cnt_r;
    assign OLastRd      = last_rd_r;
    assign OLastData    = last_data_r;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural register-file model.
module tb_wb_regfile;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        IRegWrite = 1'b0;
    logic        IRegStore = 1'b0;
    logic [15:0] IALUResult = 16'h0000;
    logic [15:0] IStoreMem = 16'h0000;
    logic [2:0]  IRd = 3'd0;
    logic [2:0]  IRs1 = 3'd0;
    logic [2:0]  IRs2 = 3'd0;
    logic [15:0] ORs1Data;
    logic [15:0] ORs2Data;
    logic [15:0] OWbData;
    logic        OWbValid;
    logic [15:0] ORetireCount;
    logic [2:0]  OLastRd;
    logic [15:0] OLastData;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [15:0] m_regs [8];
    logic [15:0] m_cnt;
    logic [2:0]  m_last_rd;
    logic [15:0] m_last_data;

    wb_regfile dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .IRegWrite    (IRegWrite),
        .IRegStore    (IRegStore),
        .IALUResult   (IALUResult),
        .IStoreMem    (IStoreMem),
        .IRd          (IRd),
        .IRs1         (IRs1),
        .IRs2         (IRs2),
        .ORs1Data     (ORs1Data),
        .ORs2Data     (ORs2Data),
        .OWbData      (OWbData),
        .OWbValid     (OWbValid),
        .ORetireCount (ORetireCount),
        .OLastRd      (OLastRd),
        .OLastData    (OLastData)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] m_sel();
        return IRegStore ? IStoreMem : IALUResult;
    endfunction

    function automatic logic m_valid();
        return IRegWrite && (IRd != 3'd0);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] idx);
        if (idx == 3'd0) return 16'h0000;
        if (m_valid() && idx == IRd) return m_sel();
        return m_regs[idx];
    endfunction

    // Model commit / reset
    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
            m_cnt       <= 16'h0000;
            m_last_rd   <= 3'd0;
            m_last_data <= 16'h0000;
        end else if (m_valid()) begin
            m_regs[IRd] <= m_sel();
            m_cnt       <= m_cnt + 16'd1;
            m_last_rd   <= IRd;
            m_last_data <= m_sel();
        end
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (chk_en) begin
            check16("cmp_rs1", ORs1Data, m_read(IRs1));
            check16("cmp_rs2", ORs2Data, m_read(IRs2));
            check16("cmp_wbdata", OWbData, m_sel());
            check16("cmp_wbvalid", {15'd0, OWbValid}, {15'd0, m_valid()});
            check16("cmp_count", ORetireCount, m_cnt);
            check16("cmp_lastrd", {13'd0, OLastRd}, {13'd0, m_last_rd});
            check16("cmp_lastdata", OLastData, m_last_data);
        end
    end

    task automatic drive(input logic we, input logic st, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
        IRegWrite = we; IRegStore = st; IALUResult = alu; IStoreMem = mem;
        IRd = rd; IRs1 = rs1; IRs2 = rs2;
    endtask

    task automatic settle();
        @(negedge CLK); #1;
    endtask

    task automatic commit();
        @(posedge CLK); #1;
    endtask

    initial begin
        // Reset state with reads requested
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd3, 3'd7);
        @(posedge CLK); #1;
        chk_en = 1'b1;
        settle();
        check16("rst_rs1", ORs1Data, 16'h0000);
        check16("rst_rs2", ORs2Data, 16'h0000);
        check16("rst_count", ORetireCount, 16'h0000);
        check16("rst_lastrd", {13'd0, OLastRd}, 16'h0000);
        commit();
        Reset = 1'b1;

        // ALU write then read back from the array
        drive(1'b1, 1'b0, 16'h1234, 16'h0000, 3'd3, 3'd0, 3'd0);
        commit();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd3, 3'd0);
        settle();
        check16("alu_rs1", ORs1Data, 16'h1234);
        check16("alu_count", ORetireCount, 16'h0001);
        check16("alu_lastrd", {13'd0, OLastRd}, 16'h0003);
        check16("alu_lastdata", OLastData, 16'h1234);
        commit();

        // Load select with bypass to both ports
        drive(1'b1, 1'b1, 16'h0001, 16'hBEEF, 3'd5, 3'd5, 3'd5);
        settle();
        check16("ld_wbdata", OWbData, 16'hBEEF);
        check16("ld_rs1", ORs1Data, 16'hBEEF);
        check16("ld_rs2", ORs2Data, 16'hBEEF);
        commit();

        // Zero register write is discarded
        drive(1'b1, 1'b0, 16'hFFFF, 16'h0000, 3'd0, 3'd0, 3'd5);
        settle();
        check16("z_rs1", ORs1Data, 16'h0000);
        check16("z_valid", {15'd0, OWbValid}, 16'h0000);
        check16("z_rs2_r5", ORs2Data, 16'hBEEF);
        commit();
        settle();
        check16("z_count", ORetireCount, 16'h0002);
        commit();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            commit();
        end

        // Mid-cycle reset loses the pending write
        drive(1'b1, 1'b0, 16'hAAAA, 16'h0000, 3'd2, 3'd2, 3'd0);
        commit();
        drive(1'b1, 1'b0, 16'h5555, 16'h0000, 3'd2, 3'd2, 3'd0);
        #2;
        Reset = 1'b0;
        #1;
        check16("mr_count_low", ORetireCount, 16'h0000);
        commit();
        Reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd2, 3'd2);
        settle();
        check16("mr_rs1", ORs1Data, 16'h0000);
        check16("mr_count", ORetireCount, 16'h0000);
        commit();

        // Counter wrap: 65536 writes to r1 starting from a reset count
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 1'b0, 16'(i) ^ 16'h5A5A, 16'h0000, 3'd1, 3'd1, 3'd4);
            commit();
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 3'd1, 3'd0);
        settle();
        check16("wrap_count", ORetireCount, 16'h0000);
        check16("wrap_r1", ORs1Data, 16'hA5A5);
        check16("wrap_lastrd", {13'd0, OLastRd}, 16'h0001);
        check16("wrap_lastdata", OLastData, 16'hA5A5);
        commit();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_regfile
